mem_port_arbiter: RTL and testbench

- Shares one single-ported, variable-latency unified memory between the instruction-fetch requester (read-only) and the data-memory stage requester (read/write).
- Sequences each access with a req/ack handshake to the memory and a one-cycle done pulse back to the winning requester.
- Produces stall signals that the hazard unit folds into PCWrite and the pipeline-register write enables.
- Guards against a hung memory with a watchdog timeout.

---
 rtl/mem_arb_pkg.sv | 9 +
 rtl/arb_watchdog.sv | 17 +
 rtl/mem_port_arbiter.sv | 91 +++++++++
 tb/tb_mem_port_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings for the unified-memory port arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_e;
  typedef enum logic {OWN_IF = 1'b0, OWN_DM = 1'b1} owner_e;
  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_WORD = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_BYTE = 2'b11;
endpackage

// File: rtl/arb_watchdog.sv
// arb_watchdog: saturating 8-bit busy-cycle counter flagging a hung memory
module arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  logic [7:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? 8'd0 : (en_i && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= 8'd0;
    else cnt_q <= cnt_d;
  assign expired_o = cnt_q == 8'(TIMEOUT - 1);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory between fetch and data ports
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter bit FAIR    = 1'b0,
  parameter int TIMEOUT = 255,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic [DW-1:0] if_rdata_o,
  output logic          if_done_o,
  output logic          if_stall_o,
  input  logic          dm_req_i,
  input  logic          dm_we_i,
  input  logic [1:0]    dm_size_i,
  input  logic [AW-1:0] dm_addr_i,
  input  logic [DW-1:0] dm_wdata_i,
  output logic [DW-1:0] dm_rdata_o,
  output logic          dm_done_o,
  output logic          dm_stall_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [1:0]    mem_size_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic          mem_ack_i,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          bus_err_o
);
  state_e state_q, state_d;
  owner_e owner_q;
  logic grant_dm, expired, wd_clr, wd_en, finish;
  logic [DW-1:0] rd_val;

  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk(clk), .rst_n(rst_n), .clr_i(wd_clr), .en_i(wd_en), .expired_o(expired)
  );

  // owner_q doubles as last-granted owner; it resets to IF so DM wins first contention
  assign grant_dm = dm_req_i & (~if_req_i | ~FAIR | (owner_q == OWN_IF));
  assign finish   = state_q == BUSY && (mem_ack_i || expired);
  assign rd_val   = mem_ack_i ? mem_rdata_i : '0;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;

  always_comb
    state_d = (state_q == IDLE) ? ((if_req_i | dm_req_i) ? BUSY : IDLE) :
              (state_q == BUSY) ? (finish ? RESP : BUSY) : IDLE;

  always_comb begin
    mem_req_o = state_q == BUSY;
    if_done_o = state_q == RESP && owner_q == OWN_IF;
    dm_done_o = state_q == RESP && owner_q == OWN_DM;
    wd_clr    = state_q == IDLE;
    wd_en     = state_q == BUSY;
  end

  assign if_stall_o = if_req_i & ~if_done_o;
  assign dm_stall_o = dm_req_i & ~dm_done_o;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      owner_q     <= OWN_IF;
      mem_we_o    <= 1'b0;
      mem_size_o  <= SZ_NONE;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      if_rdata_o  <= '0;
      dm_rdata_o  <= '0;
      bus_err_o   <= 1'b0;
    end else begin
      if (state_q == IDLE && (if_req_i || dm_req_i)) begin
        owner_q     <= grant_dm ? OWN_DM : OWN_IF;
        mem_we_o    <= grant_dm & dm_we_i;
        mem_size_o  <= grant_dm ? dm_size_i : SZ_NONE;
        mem_addr_o  <= grant_dm ? dm_addr_i : if_addr_i;
        mem_wdata_o <= grant_dm ? dm_wdata_i : '0;
      end
      if (finish) begin
        if (owner_q == OWN_DM) dm_rdata_o <= rd_val;
        else if_rdata_o <= rd_val;
        if (!mem_ack_i) bus_err_o <= 1'b1;
      end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios for fixed-priority/timeout (A) and round-robin (B) arbiters
module tb_mem_port_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;

  logic if_req_a = 0, dm_req_a = 0, dm_we_a = 0;
  logic [1:0] dm_size_a = 0;
  logic [31:0] if_addr_a = 0, dm_addr_a = 0, dm_wdata_a = 0;
  logic [31:0] if_rdata_a, dm_rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
  logic if_done_a, if_stall_a, dm_done_a, dm_stall_a, mem_req_a, mem_we_a, mem_ack_a, bus_err_a;
  logic [1:0] mem_size_a;
  logic auto_a = 0, man_ack_a = 0;
  int lat_a = 0, mcyc_a = 0;
  logic [31:0] rd_val_a = 32'h1;

  logic if_req_b = 0, dm_req_b = 0, dm_we_b = 0;
  logic [31:0] if_addr_b = 0, dm_addr_b = 0;
  logic [31:0] if_rdata_b, dm_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;
  logic if_done_b, if_stall_b, dm_done_b, dm_stall_b, mem_req_b, mem_we_b, mem_ack_b, bus_err_b;
  logic [1:0] mem_size_b;

  // memory A acks lat_a cycles into mem_req (lat_a<0: never); data is rd_val_a ^ address
  assign mem_ack_a   = auto_a | man_ack_a;
  assign mem_rdata_a = rd_val_a ^ mem_addr_a;
  always @(negedge clk) auto_a = mem_req_a && lat_a >= 0 && mcyc_a == lat_a;
  always @(posedge clk) mcyc_a <= (mem_req_a && !mem_ack_a) ? mcyc_a + 1 : 0;
  assign mem_ack_b   = mem_req_b;
  assign mem_rdata_b = mem_addr_b;

  mem_port_arbiter #(.FAIR(1'b0), .TIMEOUT(4)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req_a), .if_addr_i(if_addr_a), .if_rdata_o(if_rdata_a), .if_done_o(if_done_a), .if_stall_o(if_stall_a),
    .dm_req_i(dm_req_a), .dm_we_i(dm_we_a), .dm_size_i(dm_size_a), .dm_addr_i(dm_addr_a), .dm_wdata_i(dm_wdata_a),
    .dm_rdata_o(dm_rdata_a), .dm_done_o(dm_done_a), .dm_stall_o(dm_stall_a),
    .mem_req_o(mem_req_a), .mem_we_o(mem_we_a), .mem_size_o(mem_size_a), .mem_addr_o(mem_addr_a), .mem_wdata_o(mem_wdata_a),
    .mem_ack_i(mem_ack_a), .mem_rdata_i(mem_rdata_a), .bus_err_o(bus_err_a)
  );

  mem_port_arbiter #(.FAIR(1'b1), .TIMEOUT(255)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req_b), .if_addr_i(if_addr_b), .if_rdata_o(if_rdata_b), .if_done_o(if_done_b), .if_stall_o(if_stall_b),
    .dm_req_i(dm_req_b), .dm_we_i(dm_we_b), .dm_size_i(2'b01), .dm_addr_i(dm_addr_b), .dm_wdata_i(32'hCAFE_0000),
    .dm_rdata_o(dm_rdata_b), .dm_done_o(dm_done_b), .dm_stall_o(dm_stall_b),
    .mem_req_o(mem_req_b), .mem_we_o(mem_we_b), .mem_size_o(mem_size_b), .mem_addr_o(mem_addr_b), .mem_wdata_o(mem_wdata_b),
    .mem_ack_i(mem_ack_b), .mem_rdata_i(mem_rdata_b), .bus_err_o(bus_err_b)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    if_req_a = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if ({mem_req_a, mem_we_a, mem_size_a, if_done_a, dm_done_a, bus_err_a} !== 7'b0) begin n_bad++; $display("FAIL reset_ctrl: got %b want 0", {mem_req_a, mem_we_a, mem_size_a, if_done_a, dm_done_a, bus_err_a}); end
    n_cmp++; if ({mem_addr_a, mem_wdata_a, if_rdata_a, dm_rdata_a} !== 128'b0) begin n_bad++; $display("FAIL reset_data: got %h want 0", {mem_addr_a, mem_wdata_a, if_rdata_a, dm_rdata_a}); end
    n_cmp++; if (if_stall_a !== 1'b1) begin n_bad++; $display("FAIL reset_stall: got %b want 1", if_stall_a); end
    n_cmp++; if (mem_req_b !== 1'b0) begin n_bad++; $display("FAIL reset_b_req: got %b want 0", mem_req_b); end
    if_req_a = 1'b0;
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_lone_fetch;
    int done_at = 0, pulses = 0;
    lat_a = 2;
    rd_val_a = 32'h2008_0005 ^ 32'h10;
    if_addr_a = 32'h10;
    if_req_a = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick;
      if (k == 1) begin
        n_cmp++; if (mem_addr_a !== 32'h10) begin n_bad++; $display("FAIL fetch_addr: got %h want 00000010", mem_addr_a); end
        n_cmp++; if (mem_we_a !== 1'b0) begin n_bad++; $display("FAIL fetch_we: got %b want 0", mem_we_a); end
      end
      if (if_done_a) begin
        pulses++;
        if (done_at == 0) done_at = k;
        if_req_a = 1'b0;
      end else if (done_at == 0) begin
        n_cmp++; if ({if_stall_a, mem_req_a} !== 2'b11) begin n_bad++; $display("FAIL fetch_stall_k%0d: got %b want 11", k, {if_stall_a, mem_req_a}); end
      end
    end
    n_cmp++; if (done_at !== 4) begin n_bad++; $display("FAIL fetch_done_cycle: got %0d want 4", done_at); end
    n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL fetch_done_pulses: got %0d want 1", pulses); end
    n_cmp++; if (if_rdata_a !== 32'h2008_0005) begin n_bad++; $display("FAIL fetch_rdata: got %h want 20080005", if_rdata_a); end
  endtask

  task automatic test_contention;
    int dm_at = 0, if_at = 0;
    lat_a = 1;
    rd_val_a = 32'h5555_0000;
    if_addr_a = 32'h40; if_req_a = 1'b1;
    dm_req_a = 1'b1; dm_we_a = 1'b1; dm_size_a = 2'b01; dm_addr_a = 32'h100; dm_wdata_a = 32'hDEAD_BEEF;
    for (int k = 1; k <= 14; k++) begin
      tick;
      if (k == 1) begin
        n_cmp++; if ({mem_we_a, mem_size_a, mem_addr_a, mem_wdata_a} !== {1'b1, 2'b01, 32'h100, 32'hDEAD_BEEF}) begin n_bad++; $display("FAIL contend_dm_latch: got %h want %h", {mem_we_a, mem_size_a, mem_addr_a, mem_wdata_a}, {1'b1, 2'b01, 32'h100, 32'hDEAD_BEEF}); end
      end
      if (k == 5) begin
        n_cmp++; if ({mem_we_a, mem_size_a, mem_addr_a} !== {1'b0, 2'b00, 32'h40}) begin n_bad++; $display("FAIL contend_if_latch: got %h want %h", {mem_we_a, mem_size_a, mem_addr_a}, {1'b0, 2'b00, 32'h40}); end
      end
      if (dm_done_a && dm_at == 0) begin dm_at = k; dm_req_a = 1'b0; dm_we_a = 1'b0; end
      if (if_done_a && if_at == 0) begin if_at = k; if_req_a = 1'b0; end
    end
    n_cmp++; if (dm_at !== 3) begin n_bad++; $display("FAIL contend_dm_done: got %0d want 3", dm_at); end
    n_cmp++; if (if_at !== 7) begin n_bad++; $display("FAIL contend_if_done: got %0d want 7", if_at); end
    n_cmp++; if (if_rdata_a !== 32'h5555_0040) begin n_bad++; $display("FAIL contend_if_rdata: got %h want 55550040", if_rdata_a); end
  endtask

  task automatic test_fair;
    int n = 0;
    int at [4];
    logic seq [4];
    int exp_at [4] = '{2, 5, 8, 11};
    logic exp_seq [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin at[i] = 0; seq[i] = 1'bx; end
    dm_we_b = 1'b1; dm_addr_b = 32'h200; if_addr_b = 32'h300;
    dm_req_b = 1'b1; if_req_b = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick;
      if ((dm_done_b || if_done_b) && n < 4) begin seq[n] = dm_done_b; at[n] = k; n++; end
    end
    dm_req_b = 1'b0; if_req_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (seq[i] !== exp_seq[i] || at[i] !== exp_at[i]) begin n_bad++; $display("FAIL fair_grant%0d: got dm=%b at %0d want dm=%b at %0d", i, seq[i], at[i], exp_seq[i], exp_at[i]); end
    end
    n_cmp++; if ({dm_rdata_b, if_rdata_b} !== {32'h200, 32'h300}) begin n_bad++; $display("FAIL fair_rdata: got %h want %h", {dm_rdata_b, if_rdata_b}, {32'h200, 32'h300}); end
    tick;
  endtask

  task automatic test_timeout;
    int done_at = 0;
    lat_a = -1;
    dm_req_a = 1'b1; dm_we_a = 1'b0; dm_size_a = 2'b01; dm_addr_a = 32'h200;
    for (int k = 1; k <= 7; k++) begin
      tick;
      if (k <= 4) begin
        n_cmp++; if ({mem_req_a, dm_done_a} !== 2'b10) begin n_bad++; $display("FAIL timeout_busy_k%0d: got %b want 10", k, {mem_req_a, dm_done_a}); end
      end else if (k == 5) begin
        n_cmp++; if ({dm_done_a, bus_err_a, mem_req_a} !== 3'b110) begin n_bad++; $display("FAIL timeout_resp: got %b want 110", {dm_done_a, bus_err_a, mem_req_a}); end
        n_cmp++; if (dm_rdata_a !== 32'h0) begin n_bad++; $display("FAIL timeout_rdata: got %h want 00000000", dm_rdata_a); end
        dm_req_a = 1'b0;
        man_ack_a = 1'b1;
      end else begin
        n_cmp++; if ({mem_req_a, dm_done_a, if_done_a} !== 3'b000 || dm_rdata_a !== 32'h0) begin n_bad++; $display("FAIL late_ack_k%0d: got %b/%h want 000/0", k, {mem_req_a, dm_done_a, if_done_a}, dm_rdata_a); end
      end
    end
    man_ack_a = 1'b0;
    lat_a = 0;
    rd_val_a = 32'h0F0F_0000;
    dm_addr_a = 32'h204; dm_req_a = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick;
      if (dm_done_a && done_at == 0) begin done_at = k; dm_req_a = 1'b0; end
    end
    n_cmp++; if (done_at !== 2) begin n_bad++; $display("FAIL after_timeout_done: got %0d want 2", done_at); end
    n_cmp++; if (dm_rdata_a !== 32'h0F0F_0204) begin n_bad++; $display("FAIL after_timeout_rdata: got %h want 0f0f0204", dm_rdata_a); end
    n_cmp++; if (bus_err_a !== 1'b1) begin n_bad++; $display("FAIL bus_err_sticky: got %b want 1", bus_err_a); end
  endtask

  task automatic test_reset_mid;
    int done_at = 0;
    lat_a = -1;
    dm_req_a = 1'b1; dm_we_a = 1'b1; dm_size_a = 2'b10; dm_addr_a = 32'h300; dm_wdata_a = 32'h1234_5678;
    tick; tick;
    n_cmp++; if ({mem_req_a, mem_we_a, mem_addr_a} !== {2'b11, 32'h300}) begin n_bad++; $display("FAIL mid_busy: got %h want %h", {mem_req_a, mem_we_a, mem_addr_a}, {2'b11, 32'h300}); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if ({mem_req_a, mem_we_a, mem_size_a, if_done_a, dm_done_a, bus_err_a} !== 7'b0) begin n_bad++; $display("FAIL mid_reset_ctrl: got %b want 0", {mem_req_a, mem_we_a, mem_size_a, if_done_a, dm_done_a, bus_err_a}); end
    n_cmp++; if ({mem_addr_a, mem_wdata_a, if_rdata_a, dm_rdata_a} !== 128'b0) begin n_bad++; $display("FAIL mid_reset_data: got %h want 0", {mem_addr_a, mem_wdata_a, if_rdata_a, dm_rdata_a}); end
    dm_req_a = 1'b0; dm_we_a = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    tick;
    man_ack_a = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick;
      man_ack_a = 1'b0;
      n_cmp++; if ({mem_req_a, if_done_a, dm_done_a} !== 3'b000) begin n_bad++; $display("FAIL stray_ack_k%0d: got %b want 000", k, {mem_req_a, if_done_a, dm_done_a}); end
    end
    lat_a = 1;
    rd_val_a = 32'h3300_0000;
    if_addr_a = 32'h80; if_req_a = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick;
      if (if_done_a && done_at == 0) begin done_at = k; if_req_a = 1'b0; end
    end
    n_cmp++; if (done_at !== 3) begin n_bad++; $display("FAIL post_reset_done: got %0d want 3", done_at); end
    n_cmp++; if ({if_rdata_a, bus_err_a} !== {32'h3300_0080, 1'b0}) begin n_bad++; $display("FAIL post_reset_data: got %h want %h", {if_rdata_a, bus_err_a}, {32'h3300_0080, 1'b0}); end
  endtask

  task automatic test_back_to_back;
    int n = 0, mreq = 0;
    int at [2] = '{0, 0};
    logic [31:0] data [2] = '{32'h0, 32'h0};
    lat_a = 0;
    rd_val_a = 32'hA000_0000;
    if_addr_a = 32'h1000; if_req_a = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick;
      if (mem_req_a) mreq++;
      if (if_done_a && n < 2) begin
        at[n] = k; data[n] = if_rdata_a; n++;
        if (n == 1) if_addr_a = 32'h1004;
        else if_req_a = 1'b0;
      end
    end
    n_cmp++; if (at[0] !== 2 || at[1] !== 5) begin n_bad++; $display("FAIL b2b_done_cycles: got %0d,%0d want 2,5", at[0], at[1]); end
    n_cmp++; if (mreq !== 2) begin n_bad++; $display("FAIL b2b_mem_req_cycles: got %0d want 2", mreq); end
    n_cmp++; if (data[0] !== 32'hA000_1000 || data[1] !== 32'hA000_1004) begin n_bad++; $display("FAIL b2b_rdata: got %h,%h want a0001000,a0001004", data[0], data[1]); end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_lone_fetch;
    test_contention;
    test_fair;
    test_timeout;
    test_reset_mid;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
